// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax datapath and its downstream argmax classifier:
// Q-format element type, argmax FSM states and the index-width helper.
package softmax_pkg;

  localparam int SM_DATA_WIDTH = 16;

  typedef logic signed [SM_DATA_WIDTH-1:0] q_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SCAN = 2'd2,
    ST_HOLD = 2'd3
  } argmax_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/softmax_argmax_max_select.sv
// Single-lane signed compare-select. A candidate replaces the running best only
// when strictly greater, so on ties the earlier (lower) index is kept.
module max_select
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH = SM_DATA_WIDTH,
  parameter int IDX_W      = 7
) (
  input  logic signed [DATA_WIDTH-1:0] cand,
  input  logic        [IDX_W-1:0]      cand_idx,
  input  logic signed [DATA_WIDTH-1:0] best,
  input  logic        [IDX_W-1:0]      best_idx,
  output logic signed [DATA_WIDTH-1:0] new_best,
  output logic        [IDX_W-1:0]      new_best_idx
);

  // strict signed greater-than select
  always_comb begin
    new_best     = best;
    new_best_idx = best_idx;
    if (cand > best) begin
      new_best     = cand;
      new_best_idx = cand_idx;
    end else begin
      new_best     = best;
      new_best_idx = best_idx;
    end
  end

endmodule

// File: rtl/softmax_argmax.sv
// Top-1 classifier: requests a vector from softmax, captures it, scans serially
// for the maximum element and offers index/probability/confidence on valid/ready.
module softmax_argmax
  import softmax_pkg::*;
#(
  parameter int VEC_SIZE       = 107,
  parameter int DATA_WIDTH     = SM_DATA_WIDTH,
  parameter int FIXED_PNT      = 8,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IDX_W         = idx_width(VEC_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] conf_threshold,
  output logic                         busy,
  output logic                         sm_enable,
  input  logic                         sm_data_valid,
  input  logic signed [DATA_WIDTH-1:0] sm_vec [VEC_SIZE],
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic        [IDX_W-1:0]      res_index,
  output logic signed [DATA_WIDTH-1:0] res_prob,
  output logic                         res_confident,
  output logic                         err_timeout
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

  if ((VEC_SIZE < 1) || (TIMEOUT_CYCLES < 2) || (FIXED_PNT >= DATA_WIDTH)) begin : g_param_check
    $error("softmax_argmax: illegal parameter combination");
  end

  argmax_state_t                 state_r, state_n;
  logic          [CNT_W-1:0]     cnt_r;
  logic signed [DATA_WIDTH-1:0]  thr_r;
  logic signed [DATA_WIDTH-1:0]  buf_r [VEC_SIZE];
  logic signed [DATA_WIDTH-1:0]  best_val_r, sel_val_s, fin_val_s;
  logic          [IDX_W-1:0]     best_idx_r, idx_r, sel_idx_s, fin_idx_s;
  logic                          load_s, timeout_s, step_s, done_s, release_s;

  max_select #(.DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_max_select (
    .cand         (buf_r[idx_r]),
    .cand_idx     (idx_r),
    .best         (best_val_r),
    .best_idx     (best_idx_r),
    .new_best     (sel_val_s),
    .new_best_idx (sel_idx_s)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // next-state decode and datapath strobes
  always_comb begin
    state_n   = state_r;
    load_s    = 1'b0;
    timeout_s = 1'b0;
    step_s    = 1'b0;
    done_s    = 1'b0;
    release_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_n = ST_REQ;
        else       state_n = ST_IDLE;
      end
      ST_REQ: begin
        // a valid arriving on the final count still wins over the timeout
        if (sm_data_valid) begin
          load_s = 1'b1;
          if (VEC_SIZE == 1) begin
            done_s  = 1'b1;
            state_n = ST_HOLD;
          end else begin
            state_n = ST_SCAN;
          end
        end else if (cnt_r == CNT_LAST) begin
          timeout_s = 1'b1;
          state_n   = ST_IDLE;
        end else begin
          state_n = ST_REQ;
        end
      end
      ST_SCAN: begin
        step_s = 1'b1;
        if (idx_r == IDX_LAST) begin
          done_s  = 1'b1;
          state_n = ST_HOLD;
        end else begin
          state_n = ST_SCAN;
        end
      end
      ST_HOLD: begin
        if (res_valid && res_ready) begin
          release_s = 1'b1;
          state_n   = ST_IDLE;
        end else begin
          state_n = ST_HOLD;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // final result source: scan winner, or element 0 for a single-class vector
  always_comb begin
    fin_val_s = sel_val_s;
    fin_idx_s = sel_idx_s;
    if (state_r == ST_SCAN) begin
      fin_val_s = sel_val_s;
      fin_idx_s = sel_idx_s;
    end else begin
      fin_val_s = sm_vec[0];
      fin_idx_s = '0;
    end
  end

  // capture buffer; contents are irrelevant until loaded, so no reset
  always_ff @(posedge clk) begin
    if (load_s) begin
      buf_r <= sm_vec;
    end
  end

  // control, scan and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= '0;
      thr_r         <= '0;
      best_val_r    <= '0;
      best_idx_r    <= '0;
      idx_r         <= '0;
      busy          <= 1'b0;
      sm_enable     <= 1'b0;
      res_valid     <= 1'b0;
      res_index     <= '0;
      res_prob      <= '0;
      res_confident <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      busy        <= (state_n != ST_IDLE);
      err_timeout <= timeout_s;

      if ((state_r == ST_IDLE) && start) begin
        sm_enable <= 1'b1;
        cnt_r     <= '0;
        thr_r     <= conf_threshold;
      end else if (load_s || timeout_s) begin
        sm_enable <= 1'b0;
      end else if (state_r == ST_REQ) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end

      if (load_s) begin
        best_val_r <= sm_vec[0];
        best_idx_r <= '0;
        idx_r      <= IDX_ONE;
      end else if (step_s) begin
        best_val_r <= sel_val_s;
        best_idx_r <= sel_idx_s;
        if (!done_s) idx_r <= idx_r + IDX_ONE;
      end

      if (done_s) begin
        res_valid     <= 1'b1;
        res_index     <= fin_idx_s;
        res_prob      <= fin_val_s;
        res_confident <= (fin_val_s >= thr_r);
      end else if (release_s) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/softmax_argmax.md
# softmax_argmax

Top-1 classifier that sits downstream of the softmax stage and drives it as the requesting end of its enable/data_valid handshake. On `start` it raises the softmax `enable`, holds it until the one-cycle `data_valid` pulse, and captures the probability vector. It then scans the vector serially for the largest element and presents index, probability and a confidence flag on a valid/ready output port.

## Interface
- VEC_SIZE, 107, number of classes (≥1)
- DATA_WIDTH, 16, signed element width
- FIXED_PNT, 8, fractional bits (Q format shared with softmax)
- TIMEOUT_CYCLES, 16, max cycles `sm_enable` is held waiting for `sm_data_valid` (≥2)
- IDX_W (localparam), max(1,$clog2(VEC_SIZE))
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request one classification; sampled only in IDLE
- conf_threshold  in  DATA_WIDTH  signed Q threshold; sampled with `start`
- busy  out  1  state != IDLE
- sm_enable  out  1  enable to softmax; registered
- sm_data_valid  in  1  softmax output-ready pulse
- sm_vec  in  VEC_SIZE x DATA_WIDTH signed  softmax output vector
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_index  out  IDX_W  index of maximum element
- res_prob  out  DATA_WIDTH signed  value of maximum element
- res_confident  out  1  res_prob >= threshold (signed)
- err_timeout  out  1  one-cycle pulse on handshake timeout

## Operation
- FSM states: IDLE, REQ, SCAN, HOLD.
- IDLE:
  - `start`=1 → REQ.
  - Set `sm_enable`=1, clear the timeout counter, latch `conf_threshold`.
- REQ:
  - `sm_enable` held at 1.
  - On `sm_data_valid`=1:
    - Capture all of `sm_vec` into the local buffer.
    - Init best_val=`sm_vec[0]`, best_idx=0, scan idx=1.
    - `sm_enable`→0; go to SCAN, or to HOLD directly if VEC_SIZE=1.
  - Otherwise, the counter increments. At count==TIMEOUT_CYCLES-1 without valid:
    - `sm_enable`→0, `err_timeout`=1 for one cycle.
    - Go to IDLE; no result is produced.
  - `sm_data_valid` on the timeout edge wins over the timeout.
- SCAN:
  - One element per cycle.
  - If buf[idx] > best_val (signed, strict), update best_val and best_idx. Ties therefore keep the lowest index.
  - After processing idx==VEC_SIZE-1, load `res_index`/`res_prob`/`res_confident` and go to HOLD.
- HOLD:
  - `res_valid`=1; result outputs stable.
  - `res_valid & res_ready` → IDLE; `res_valid`→0 next cycle.
- `start` outside IDLE is ignored, including in the HOLD handshake cycle.
- `sm_data_valid` outside REQ is ignored; the buffer is not overwritten.
- Width rules:
  - Compare is full DATA_WIDTH signed; no saturation.
  - The index counter is IDX_W bits and never wraps (stops at VEC_SIZE-1).
- Reset: asynchronous and valid in any state.
  - FSM→IDLE immediately.
  - All outputs 0: `busy`, `sm_enable`, `res_valid`, `res_index`, `res_prob`, `res_confident`, `err_timeout`.
  - Buffer contents are don't-care.

## Timing
- `start` sampled at edge S → `sm_enable`=1 and `busy`=1 from S.
- `sm_data_valid` sampled at edge V → `sm_enable`=0 from V.
- `res_valid`=1 from edge V+VEC_SIZE-1 (106 cycles for the default; edge V itself when VEC_SIZE=1).
- Timeout: `sm_enable` is high for exactly TIMEOUT_CYCLES cycles; `err_timeout` is high for the following cycle.
- Minimum `start`-to-`start` interval: softmax latency + VEC_SIZE + 1 cycles.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package `softmax_pkg`:
  - State enum `argmax_state_t`.
  - Q-format typedef `q_t` (signed [DATA_WIDTH-1:0]).
  - IDX_W helper function.
  - Shared with softmax for width consistency.
- One sub-module, `max_select`: combinational signed compare-select (cand, cand_idx, best, best_idx → new best, new best_idx, strict greater-than). This keeps a later multi-lane scan a drop-in replacement.

## Test plan
- Single peak:
  - Stimulus: all elements 0x0000 except [42]=0x00C0, threshold 0x0080.
  - Response: res_index=42, res_prob=0x00C0, res_confident=1, `res_valid` at V+106.
- Tie and low confidence:
  - Stimulus: [5]=[70]=0x0040, others 0x0010, threshold 0x0080.
  - Response: res_index=5, res_confident=0.
- Edge positions and signed compare:
  - Stimulus: all elements 0xFF00 (−1.0) except [106]=0xFF80.
  - Response: res_index=106, res_prob=0xFF80.
  - Repeat with the peak at [0] → res_index=0.
- Backpressure:
  - Stimulus: `res_ready` low for 10 cycles in HOLD, pulse `start` and `sm_data_valid` meanwhile.
  - Response: outputs stable, no state change. After `res_ready`=1, `res_valid`=0 and `busy`=0 next cycle.
- Timeout:
  - Stimulus: `sm_data_valid` never asserted.
  - Response: `sm_enable` high exactly 16 cycles, one `err_timeout` pulse, return to IDLE, no `res_valid`.
  - Repeat with valid on the 16th cycle → normal result, no error.
- Reset mid-SCAN:
  - Stimulus: `rst_n` low at idx=50.
  - Response: all outputs 0 immediately. The next full transaction returns the correct result.
